// File: rtl/asip_pkg.sv
// Shared types and sizing for the vector store path.
package asip_pkg;

    // Serializer control state.
    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } store_state_t;

    localparam int VEC_SIZE = 4;
    localparam int REG_SIZE = 8;

    // Element-index width; a single-element vector still gets a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDX_W = idx_width(VEC_SIZE);

endpackage

// File: rtl/register.sv
// Enabled register with synchronous active-high reset.
module register #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] val_q;
    logic [WIDTH-1:0] val_d;

    // Load on enable, otherwise hold.
    always_comb begin
        val_d = val_q;
        if (en) val_d = d;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) val_q <= '0;
        else       val_q <= val_d;
    end

    assign q = val_q;

endmodule

// File: rtl/vector_element_select.sv
// Picks one element out of a packed vector by index. Used for both the
// data word and the per-element mask bit.
module vector_element_select
    import asip_pkg::*;
#(
    parameter int vecSize      = VEC_SIZE,
    parameter int registerSize = REG_SIZE,
    parameter int IW           = idx_width(vecSize)
) (
    input  logic [vecSize-1:0][registerSize-1:0] vec,
    input  logic [IW-1:0]                        idx,
    output logic [registerSize-1:0]              elem
);

    assign elem = vec[idx];

endmodule

// File: rtl/vector_store_serializer.sv
// Serializes one full-vector store into element-wide memory writes,
// honouring memory back-pressure and skipping masked-off elements.
module vector_store_serializer
    import asip_pkg::*;
#(
    parameter int vecSize      = VEC_SIZE,
    parameter int registerSize = REG_SIZE
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic [registerSize-1:0]              req_address,
    input  logic [vecSize-1:0][registerSize-1:0] req_data,
    input  logic [vecSize-1:0]                   req_mask,
    input  logic                                 mem_ready,
    output logic                                 mem_we,
    output logic [registerSize-1:0]              mem_addr,
    output logic [registerSize-1:0]              mem_wdata,
    output logic                                 busy,
    output logic                                 done
);

    localparam int            IW   = idx_width(vecSize);
    localparam logic [IW-1:0] LAST = IW'(vecSize - 1);

    store_state_t                         state_q, state_d;
    logic [IW-1:0]                        idx_q, idx_d;
    logic [vecSize-1:0][registerSize-1:0] data_q, data_d;
    logic [vecSize-1:0]                   mask_q, mask_d;
    logic                                 done_q, done_d;

    logic [registerSize-1:0] addr_q;
    logic [registerSize-1:0] cur_data;
    logic [0:0]              cur_mask;
    logic                    accept;
    logic                    retire;

    // Only IDLE advertises ready, so accept never depends on outputs.
    assign accept = (state_q == IDLE) && req_valid;

    // Masked-off elements never wait on the memory.
    assign retire = (state_q == WRITE) && (mem_ready || !cur_mask[0]);

    register #(.WIDTH(registerSize)) u_addr (
        .clk   (clk),
        .reset (reset),
        .en    (accept),
        .d     (req_address),
        .q     (addr_q)
    );

    vector_element_select #(.vecSize(vecSize), .registerSize(registerSize)) u_data_sel (
        .vec  (data_q),
        .idx  (idx_q),
        .elem (cur_data)
    );

    vector_element_select #(.vecSize(vecSize), .registerSize(1)) u_mask_sel (
        .vec  (mask_q),
        .idx  (idx_q),
        .elem (cur_mask)
    );

    // Next-state: latch on accept, step the index on each retire.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        mask_d  = mask_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d  = req_data;
                    mask_d  = req_mask;
                    idx_d   = '0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (retire) begin
                    if (idx_q == LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset drops any in-flight store.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            mask_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            done_q  <= done_d;
        end
    end

    // Outputs come from registered state only; address wraps at registerSize.
    always_comb begin
        req_ready = (state_q == IDLE);
        busy      = (state_q == WRITE);
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == WRITE) begin
            mem_we    = cur_mask[0];
            mem_addr  = addr_q + registerSize'(idx_q);
            mem_wdata = cur_data;
        end
        done = done_q;
    end

endmodule

// File: tb/tb_vector_store_serializer.sv
// Scenario bench for vector_store_serializer with a write scoreboard.
module tb_vector_store_serializer;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [7:0]       req_address = '0;
    logic [3:0][7:0]  req_data = '0;
    logic [3:0]       req_mask = '0;
    logic             mem_ready = 1'b1;
    logic             mem_we;
    logic [7:0]       mem_addr;
    logic [7:0]       mem_wdata;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;
    logic [15:0] sb[$];   // {addr, data} of each expected write

    vector_store_serializer #(.vecSize(4), .registerSize(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_address (req_address),
        .req_data    (req_data),
        .req_mask    (req_mask),
        .mem_ready   (mem_ready),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Every accepted write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (mem_we === 1'b1 && mem_ready === 1'b1) begin
            logic [15:0] exp;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got addr=%h data=%h want none", mem_addr, mem_wdata);
            end else begin
                exp = sb.pop_front();
                if ({mem_addr, mem_wdata} !== exp) begin
                    errors++;
                    $display("FAIL sb_write got addr=%h data=%h want addr=%h data=%h",
                             mem_addr, mem_wdata, exp[15:8], exp[7:0]);
                end
            end
        end
    end

    task automatic push_exp(input logic [7:0] a, input logic [3:0][7:0] d, input logic [3:0] m, input int n);
        for (int i = 0; i < n; i++)
            if (m[i]) sb.push_back({8'(a + 8'(i)), d[i]});
    endtask

    // Present a request for one edge; returns at the start of cycle T+1.
    task automatic send(input logic [7:0] a, input logic [3:0][7:0] d, input logic [3:0] m);
        @(posedge clk); #1;
        req_valid = 1'b1; req_address = a; req_data = d; req_mask = m;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Sample n cycles starting at T+1 and summarize what was seen.
    task automatic observe(input int n, output int busy_cnt, output int done_at,
                           output int we_cnt, output logic rdy_at_done);
        busy_cnt = 0; done_at = -1; we_cnt = 0; rdy_at_done = 1'b0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (mem_we === 1'b1) we_cnt++;
            if (done === 1'b1 && done_at < 0) begin
                done_at = k;
                rdy_at_done = req_ready;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({req_ready, busy, done, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}) begin
            errors++;
            $display("FAIL reset_state got rdy=%b busy=%b done=%b we=%b addr=%h data=%h want 1 0 0 0 00 00",
                     req_ready, busy, done, mem_we, mem_addr, mem_wdata);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_full_store();
        int b, d, w; logic r;
        push_exp(8'h10, {8'h44, 8'h33, 8'h22, 8'h11}, 4'b1111, 4);
        send(8'h10, {8'h44, 8'h33, 8'h22, 8'h11}, 4'b1111);
        observe(7, b, d, w, r);
        checks++; if (b !== 4) begin errors++; $display("FAIL full_busy got %0d want 4", b); end
        checks++; if (d !== 5) begin errors++; $display("FAIL full_done got %0d want 5", d); end
        checks++; if (r !== 1'b1) begin errors++; $display("FAIL full_ready_at_done got %b want 1", r); end
        checks++; if (w !== 4) begin errors++; $display("FAIL full_we_count got %0d want 4", w); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL full_sb_left got %0d want 0", sb.size()); end
    endtask

    task automatic test_masked();
        int b, d, w; logic r;
        push_exp(8'h10, {8'h44, 8'h33, 8'h22, 8'h11}, 4'b0101, 4);
        send(8'h10, {8'h44, 8'h33, 8'h22, 8'h11}, 4'b0101);
        observe(7, b, d, w, r);
        checks++; if (w !== 2) begin errors++; $display("FAIL mask_we_count got %0d want 2", w); end
        checks++; if (b !== 4) begin errors++; $display("FAIL mask_busy got %0d want 4", b); end
        checks++; if (d !== 5) begin errors++; $display("FAIL mask_done got %0d want 5", d); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL mask_sb_left got %0d want 0", sb.size()); end
    endtask

    // Masked-off elements must retire even with the memory stalled.
    task automatic test_zero_mask();
        int b, d, w; logic r;
        mem_ready = 1'b0;
        send(8'h20, {8'hAA, 8'hBB, 8'hCC, 8'hDD}, 4'b0000);
        observe(7, b, d, w, r);
        mem_ready = 1'b1;
        checks++; if (w !== 0) begin errors++; $display("FAIL zero_we_count got %0d want 0", w); end
        checks++; if (b !== 4) begin errors++; $display("FAIL zero_busy got %0d want 4", b); end
        checks++; if (d !== 5) begin errors++; $display("FAIL zero_done got %0d want 5", d); end
    endtask

    task automatic test_wrap();
        int b, d, w; logic r;
        push_exp(8'hFE, {8'h04, 8'h03, 8'h02, 8'h01}, 4'b1111, 4);
        send(8'hFE, {8'h04, 8'h03, 8'h02, 8'h01}, 4'b1111);
        observe(7, b, d, w, r);
        checks++; if (d !== 5) begin errors++; $display("FAIL wrap_done got %0d want 5", d); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL wrap_sb_left got %0d want 0", sb.size()); end
    endtask

    // Memory stalls element 1 for three cycles.
    task automatic test_stall();
        int hold_ok = 0; int done_at = -1;
        push_exp(8'h10, {8'h44, 8'h33, 8'h22, 8'h11}, 4'b1111, 4);
        send(8'h10, {8'h44, 8'h33, 8'h22, 8'h11}, 4'b1111);
        for (int k = 1; k <= 10; k++) begin
            mem_ready = !(k >= 2 && k <= 4);
            @(negedge clk);
            if (k >= 2 && k <= 5 && mem_we === 1'b1 && mem_addr === 8'h11 && mem_wdata === 8'h22) hold_ok++;
            if (done === 1'b1 && done_at < 0) done_at = k;
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        checks++; if (hold_ok !== 4) begin errors++; $display("FAIL stall_hold got %0d want 4", hold_ok); end
        checks++; if (done_at !== 8) begin errors++; $display("FAIL stall_done got %0d want 8", done_at); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL stall_sb_left got %0d want 0", sb.size()); end
    endtask

    // Reset lands while element 2 is on the bus.
    task automatic test_reset_mid();
        int dn = 0; int b, d, w; logic r;
        push_exp(8'h30, {8'h04, 8'h03, 8'h02, 8'h01}, 4'b0111, 4);
        send(8'h30, {8'h04, 8'h03, 8'h02, 8'h01}, 4'b1111);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k < 3) begin @(posedge clk); #1; end
        end
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({mem_we, busy, req_ready, done} !== 4'b0010) begin
            errors++;
            $display("FAIL rst_mid_state got we=%b busy=%b rdy=%b done=%b want 0 0 1 0", mem_we, busy, req_ready, done);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done === 1'b1 || mem_we === 1'b1) dn++;
            @(posedge clk); #1;
        end
        checks++; if (dn !== 0) begin errors++; $display("FAIL rst_mid_quiet got %0d want 0", dn); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL rst_mid_sb_left got %0d want 0", sb.size()); end
        push_exp(8'h40, {8'h5D, 8'h5C, 8'h5B, 8'h5A}, 4'b1111, 4);
        send(8'h40, {8'h5D, 8'h5C, 8'h5B, 8'h5A}, 4'b1111);
        observe(7, b, d, w, r);
        checks++; if (d !== 5) begin errors++; $display("FAIL rst_fresh_done got %0d want 5", d); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL rst_fresh_sb_left got %0d want 0", sb.size()); end
    endtask

    task automatic test_back_to_back();
        int busy_cnt = 0; int done_cnt = 0; int first_b = -1;
        logic ok5 = 1'b0;
        push_exp(8'h50, {8'h14, 8'h13, 8'h12, 8'h11}, 4'b1111, 4);
        push_exp(8'h80, {8'h24, 8'h23, 8'h22, 8'h21}, 4'b1111, 4);
        @(posedge clk); #1;
        req_valid = 1'b1; req_address = 8'h50; req_data = {8'h14, 8'h13, 8'h12, 8'h11}; req_mask = 4'b1111;
        @(posedge clk); #1;
        req_address = 8'h80; req_data = {8'h24, 8'h23, 8'h22, 8'h21};
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) done_cnt++;
            if (k == 5) ok5 = (done === 1'b1 && req_ready === 1'b1);
            if (mem_we === 1'b1 && mem_addr === 8'h80 && first_b < 0) first_b = k;
            @(posedge clk); #1;
            if (k == 5) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        checks++; if (ok5 !== 1'b1) begin errors++; $display("FAIL b2b_done_ready got %b want 1", ok5); end
        checks++; if (first_b !== 6) begin errors++; $display("FAIL b2b_first_write got %0d want 6", first_b); end
        checks++; if (busy_cnt !== 8) begin errors++; $display("FAIL b2b_busy got %0d want 8", busy_cnt); end
        checks++; if (done_cnt !== 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", done_cnt); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL b2b_sb_left got %0d want 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_full_store();
        test_masked();
        test_zero_mask();
        test_wrap();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
